timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
Control sequencer for the MM:SS countdown timer datapath (mod10/mod06 seconds chain, BCD minute down-counters, 7-segment display driver). Turns user buttons and the 1 Hz tick into the datapath's load, count-enable and clear strobes. Runs the IDLE/RUN/PAUSE/ALARM flow, blanks the display while paused, and drives the alarm LED. Sits between the button/switch inputs and the timer datapath, in the same clock domain as both.

Parameters:
ALARM_SECS, 10, number of tick_1hz pulses spent in ALARM before returning to IDLE (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_1hz  in  1  one-cycle pulse, once per second, from the 1 Hz divider
btn_start  in  1  start/pause/acknowledge button level, already synchronised to clk
btn_set  in  1  load-preset button level, already synchronised
btn_clear  in  1  clear button level, already synchronised
set_m1  in  4  preset minutes tens digit, BCD
set_m0  in  4  preset minutes ones digit, BCD
cnt_zero  in  1  high when the datapath shows 00:00
load  out  1  one-cycle load strobe to the minute down-counters
preset_m1  out  4  registered tens digit presented with load
preset_m0  out  4  registered ones digit presented with load
ce  out  1  one-cycle count-enable to the seconds chain
clr  out  1  one-cycle synchronous clear to the datapath
blank  out  1  display blank (blink) request
alarm  out  1  alarm LED
err  out  1  one-cycle pulse: preset rejected
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM

Behaviour:
- All outputs are registered. On reset: state=IDLE, loaded flag=0, alarm tick counter=0, every output 0 including preset_m1/m0. Reset takes effect at any time, including mid-RUN or mid-ALARM.
- Buttons are rising-edge detected with a one-register history that resets to 0. A button held high through reset release does not produce an edge.
- Latency: an edge seen in cycle N produces its strobe and state change at the clock edge ending cycle N, so outputs are visible in cycle N+1.
- Priority when several edges arrive in one cycle: clear > set > start. Only the winner acts.
- clear edge (any state): clr=1 for one cycle, go to IDLE, loaded=0, alarm=0, blank=0.
- set edge, IDLE or PAUSE only:
  - Valid preset (set_m1<=9, set_m0<=9, and not both 0): latch preset_m1/m0, load=1 for one cycle, loaded=1, go to IDLE.
  - Invalid preset: err=1 for one cycle. No load, no state change, preset outputs unchanged.
  - In RUN or ALARM: the set edge is ignored.
- start edge:
  - IDLE with loaded=1 and cnt_zero=0: go to RUN. Otherwise ignored.
  - RUN: go to PAUSE.
  - PAUSE: go to RUN.
  - ALARM: go to IDLE, alarm=0, loaded=0.
- RUN:
  - ce=1 in the cycle after a tick_1hz sampled with cnt_zero=0 and no winning button edge in that cycle.
  - A tick coinciding with a start (pause) edge produces no ce.
  - cnt_zero sampled high: go to ALARM. ce is never asserted while cnt_zero=1.
- PAUSE: ce=0. blank toggles on each tick_1hz, starting from 0 on entry, and is forced to 0 on leaving PAUSE.
- ALARM:
  - Entry sets alarm=1 and the tick counter to 0.
  - Each tick toggles alarm and increments the counter.
  - When the counter reaches ALARM_SECS, go to IDLE with alarm=0 and loaded=0.
  - ce=0 throughout ALARM.
- The state output always reflects the registered current state.

Test Plan:
- Reset: hold reset for 3 cycles with buttons high -> all outputs 0, state=00. Release with btn_start still high -> no transition.
- Preset: set_m1=2, set_m0=5, set edge -> one-cycle load with preset=2/5, state stays IDLE. Then set_m0=4'hA with a set edge -> err pulse, no load, preset stays 2/5.
- Run/pause: after load, start edge -> state=01, one ce per tick_1hz. Start edge coinciding with a tick -> state=10, no ce. Next 2 ticks -> blank toggles 1 then 0. Start edge -> state=01, blank=0.
- Expiry: in RUN, raise cnt_zero -> no further ce, state=11, alarm=1. With ALARM_SECS=4, after 4 ticks -> state=00, alarm=0. A start edge afterwards is ignored (loaded=0).
- Priority: clear, set and start edges in the same cycle during RUN -> only clr pulses, state=00, no load.
- Acknowledge: in ALARM after 1 tick, start edge -> state=00, alarm=0 in the next cycle.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Button/tick inputs and datapath strobes exchanged between the timer controller
// and its surroundings; master is the controller, slave is the bench or datapath side.
interface timer_ctrl_if;
    logic       tick_1hz;
    logic       btn_start;
    logic       btn_set;
    logic       btn_clear;
    logic [3:0] set_m1;
    logic [3:0] set_m0;
    logic       cnt_zero;
    logic       load;
    logic [3:0] preset_m1;
    logic [3:0] preset_m0;
    logic       ce;
    logic       clr;
    logic       blank;
    logic       alarm;
    logic       err;
    logic [1:0] state;

    modport master (
        input  tick_1hz, btn_start, btn_set, btn_clear, set_m1, set_m0, cnt_zero,
        output load, preset_m1, preset_m0, ce, clr, blank, alarm, err, state
    );

    modport slave (
        output tick_1hz, btn_start, btn_set, btn_clear, set_m1, set_m0, cnt_zero,
        input  load, preset_m1, preset_m0, ce, clr, blank, alarm, err, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// MM:SS countdown control sequencer: IDLE/RUN/PAUSE/ALARM flow producing
// registered load/ce/clr strobes, pause blinking and the alarm LED.
module timer_ctrl #(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        ALARM = 2'b11
    } state_t;

    localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECS);

    function automatic logic preset_ok(input logic [3:0] m1, input logic [3:0] m0);
        return (m1 <= 4'd9) && (m0 <= 4'd9) && ((m1 != 4'd0) || (m0 != 4'd0));
    endfunction

    state_t     state_r, state_s;
    logic       loaded_r, loaded_s;
    logic [7:0] secs_r, secs_s;
    logic       armed_r;
    logic       start_q_r, set_q_r, clear_q_r;
    logic       load_r, load_s;
    logic [3:0] pm1_r, pm1_s, pm0_r, pm0_s;
    logic       ce_r, ce_s;
    logic       clr_r, clr_s;
    logic       blank_r, blank_s;
    logic       alarm_r, alarm_s;
    logic       err_r, err_s;
    logic       start_e_s, set_e_s, clear_e_s;
    logic       set_act_s, start_act_s;

    // The first cycle after reset only primes the history, so a held button is not an edge.
    assign start_e_s = armed_r & bus.btn_start & ~start_q_r;
    assign set_e_s   = armed_r & bus.btn_set   & ~set_q_r;
    assign clear_e_s = armed_r & bus.btn_clear & ~clear_q_r;

    // Edges that would do nothing in the current state do not win priority.
    assign set_act_s   = set_e_s & ((state_r == IDLE) | (state_r == PAUSE));
    assign start_act_s = start_e_s & ~((state_r == IDLE) & (~loaded_r | bus.cnt_zero));

    // Next-state and next-output decision for one cycle.
    always_comb begin
        state_s  = state_r;
        loaded_s = loaded_r;
        secs_s   = secs_r;
        pm1_s    = pm1_r;
        pm0_s    = pm0_r;
        blank_s  = blank_r;
        alarm_s  = alarm_r;
        load_s   = 1'b0;
        ce_s     = 1'b0;
        clr_s    = 1'b0;
        err_s    = 1'b0;
        if (clear_e_s) begin
            clr_s    = 1'b1;
            state_s  = IDLE;
            loaded_s = 1'b0;
            alarm_s  = 1'b0;
            blank_s  = 1'b0;
        end else if (set_act_s) begin
            if (preset_ok(bus.set_m1, bus.set_m0)) begin
                pm1_s    = bus.set_m1;
                pm0_s    = bus.set_m0;
                load_s   = 1'b1;
                loaded_s = 1'b1;
                state_s  = IDLE;
                blank_s  = 1'b0;
            end else begin
                err_s = 1'b1;
            end
        end else if (start_act_s) begin
            blank_s = 1'b0;
            unique case (state_r)
                IDLE:    state_s = RUN;
                RUN:     state_s = PAUSE;
                PAUSE:   state_s = RUN;
                ALARM: begin
                    state_s  = IDLE;
                    alarm_s  = 1'b0;
                    loaded_s = 1'b0;
                end
                default: state_s = IDLE;
            endcase
        end else begin
            unique case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    if (bus.cnt_zero) begin
                        state_s = ALARM;
                        alarm_s = 1'b1;
                        secs_s  = 8'd0;
                    end else begin
                        ce_s = bus.tick_1hz;
                    end
                end
                PAUSE: begin
                    if (bus.tick_1hz) begin
                        blank_s = ~blank_r;
                    end else begin
                        blank_s = blank_r;
                    end
                end
                ALARM: begin
                    if (bus.tick_1hz) begin
                        if ((secs_r + 8'd1) == ALARM_LIMIT) begin
                            state_s  = IDLE;
                            alarm_s  = 1'b0;
                            loaded_s = 1'b0;
                            secs_s   = 8'd0;
                        end else begin
                            alarm_s = ~alarm_r;
                            secs_s  = secs_r + 8'd1;
                        end
                    end else begin
                        secs_s = secs_r;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State, flags, button history and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            loaded_r  <= 1'b0;
            secs_r    <= 8'd0;
            armed_r   <= 1'b0;
            start_q_r <= 1'b0;
            set_q_r   <= 1'b0;
            clear_q_r <= 1'b0;
            load_r    <= 1'b0;
            pm1_r     <= 4'd0;
            pm0_r     <= 4'd0;
            ce_r      <= 1'b0;
            clr_r     <= 1'b0;
            blank_r   <= 1'b0;
            alarm_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            loaded_r  <= loaded_s;
            secs_r    <= secs_s;
            armed_r   <= 1'b1;
            start_q_r <= bus.btn_start;
            set_q_r   <= bus.btn_set;
            clear_q_r <= bus.btn_clear;
            load_r    <= load_s;
            pm1_r     <= pm1_s;
            pm0_r     <= pm0_s;
            ce_r      <= ce_s;
            clr_r     <= clr_s;
            blank_r   <= blank_s;
            alarm_r   <= alarm_s;
            err_r     <= err_s;
        end
    end

    assign bus.load      = load_r;
    assign bus.preset_m1 = pm1_r;
    assign bus.preset_m0 = pm0_r;
    assign bus.ce        = ce_r;
    assign bus.clr       = clr_r;
    assign bus.blank     = blank_r;
    assign bus.alarm     = alarm_r;
    assign bus.err       = err_r;
    assign bus.state     = state_r;

endmodule
